// File: rtl/route_sequencer_if.sv
// route_sequencer_if: start/ready/done handshake plus register-file and ALU buses of the sequencer
interface route_sequencer_if #(parameter int w = 8, parameter int sel_w = 4);
  logic             start;
  logic             ready;
  logic             busy;
  logic             done;
  logic [0:5]       flags;
  logic [w-1:0]     i1;
  logic [w-1:0]     i2;
  logic [w-1:0]     i3;
  logic [w-1:0]     x;
  logic [w-1:0]     y;
  logic [w-1:0]     result;
  logic [w-1:0]     a;
  logic [w-1:0]     b;
  logic [w-1:0]     z;
  logic [sel_w-1:0] x_sel;
  logic [sel_w-1:0] y_sel;
  logic [sel_w-1:0] z_sel;
  logic             x_enb;
  logic             y_enb;
  logic             z_enb;
  modport master (
    output start, flags, i1, i2, i3, x, y, result,
    input  ready, busy, done, a, b, z, x_sel, y_sel, z_sel, x_enb, y_enb, z_enb
  );
  modport slave (
    input  start, flags, i1, i2, i3, x, y, result,
    output ready, busy, done, a, b, z, x_sel, y_sel, z_sel, x_enb, y_enb, z_enb
  );
endinterface

// File: rtl/route_sequencer.sv
// route_sequencer: synchronous FSM sequencing register reads, ALU operand hold/wait and write-back
module route_sequencer #(
  parameter int w        = 8,
  parameter int sel_w    = 4,
  parameter int flags_w  = 6,
  parameter int ALU_WAIT = 1
) (
  input logic              clk,
  input logic              reset,
  route_sequencer_if.slave bus
);
  localparam int CW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_EXEC, S_WRITE, S_DONE} state_t;
  state_t             r_state;
  logic [0:flags_w-1] r_f;
  logic [sel_w-1:0]   r_i1;
  logic [w-1:0]       r_i2;
  logic [w-1:0]       r_i3;
  logic [w-1:0]       r_y;
  logic [CW-1:0]      r_cnt;
  logic               r_ready;
  logic               r_done;
  logic               r_xen;
  logic               r_yen;
  logic               r_zen;
  logic [w-1:0]       r_a;
  logic [w-1:0]       r_b;
  logic [w-1:0]       r_z;
  logic [sel_w-1:0]   r_xs;
  logic [sel_w-1:0]   r_ys;
  logic [sel_w-1:0]   r_zs;
  logic               w_wr;
  logic [w-1:0]       w_z;
  // a write only happens when requested and a z source is selected
  assign w_wr = r_f[3] & (r_f[0:1] != 2'd0);
  // z source: 1=immediate i2, 2=captured x (held in a), 3=ALU result
  assign w_z = (r_f[0:1] == 2'd1) ? r_i2 : (r_f[0:1] == 2'd2) ? r_a : bus.result;
  assign bus.ready = r_ready;
  assign bus.busy  = ~r_ready;
  assign bus.done  = r_done;
  assign bus.x_enb = r_xen;
  assign bus.y_enb = r_yen;
  assign bus.z_enb = r_zen;
  assign bus.a     = r_a;
  assign bus.b     = r_b;
  assign bus.z     = r_z;
  assign bus.x_sel = r_xs;
  assign bus.y_sel = r_ys;
  assign bus.z_sel = r_zs;
  // sequencer FSM; every output is registered and set on entry to the state that shows it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_f     <= '0;
      r_i1    <= '0;
      r_i2    <= '0;
      r_i3    <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_xen   <= 1'b0;
      r_yen   <= 1'b0;
      r_zen   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_z     <= '0;
      r_xs    <= '0;
      r_ys    <= '0;
      r_zs    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_f     <= bus.flags;
          r_i1    <= bus.i1[sel_w-1:0];
          r_i2    <= bus.i2;
          r_i3    <= bus.i3;
          r_ready <= 1'b0;
          if (bus.flags[4] | bus.flags[5]) begin
            r_state <= S_READ;
            r_xen   <= bus.flags[4];
            r_yen   <= bus.flags[5];
            r_xs    <= bus.i2[sel_w-1:0];
            r_ys    <= bus.i3[sel_w-1:0];
          end else begin
            r_state <= S_EXEC;
            r_cnt   <= CW'(ALU_WAIT - 1);
            r_b     <= bus.flags[2] ? r_y : bus.i3;
          end
        end
        S_READ: begin
          r_xen   <= 1'b0;
          r_yen   <= 1'b0;
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (r_f[4]) r_a <= bus.x;
          if (r_f[5]) r_y <= bus.y;
          r_b     <= r_f[2] ? (r_f[5] ? bus.y : r_y) : r_i3;
          r_cnt   <= CW'(ALU_WAIT - 1);
          r_state <= S_EXEC;
        end
        S_EXEC: if (r_cnt == '0) begin
          r_state <= w_wr ? S_WRITE : S_DONE;
          r_done  <= ~w_wr;
          r_zen   <= w_wr;
          if (w_wr) begin
            r_zs <= r_i1;
            r_z  <= w_z;
          end
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        S_WRITE: begin
          r_zen   <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_route_sequencer.sv
// tb_route_sequencer: table vectors, hand sequences and random ops against a per-cycle timeline model
module tb_route_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic sel;
  logic start;
  logic [0:5] flags;
  logic [7:0] i1, i2, i3, x, y, result;
  int total = 0;
  int bad = 0;
  route_sequencer_if if1 ();
  route_sequencer_if if3 ();
  route_sequencer #(.ALU_WAIT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  route_sequencer #(.ALU_WAIT(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));
  always #5 clk = ~clk;
  assign if1.start = start & ~sel;
  assign if3.start = start & sel;
  assign if1.flags = flags;
  assign if3.flags = flags;
  assign if1.i1 = i1;
  assign if3.i1 = i1;
  assign if1.i2 = i2;
  assign if3.i2 = i2;
  assign if1.i3 = i3;
  assign if3.i3 = i3;
  assign if1.x = x;
  assign if3.x = x;
  assign if1.y = y;
  assign if3.y = y;
  assign if1.result = result;
  assign if3.result = result;
  logic o_ready, o_busy, o_done, o_xen, o_yen, o_zen;
  logic [7:0] o_a, o_b, o_z;
  logic [3:0] o_xs, o_ys, o_zs;
  assign o_ready = sel ? if3.ready : if1.ready;
  assign o_busy  = sel ? if3.busy  : if1.busy;
  assign o_done  = sel ? if3.done  : if1.done;
  assign o_xen   = sel ? if3.x_enb : if1.x_enb;
  assign o_yen   = sel ? if3.y_enb : if1.y_enb;
  assign o_zen   = sel ? if3.z_enb : if1.z_enb;
  assign o_a     = sel ? if3.a     : if1.a;
  assign o_b     = sel ? if3.b     : if1.b;
  assign o_z     = sel ? if3.z     : if1.z;
  assign o_xs    = sel ? if3.x_sel : if1.x_sel;
  assign o_ys    = sel ? if3.y_sel : if1.y_sel;
  assign o_zs    = sel ? if3.z_sel : if1.z_sel;
  logic [7:0] ma [2], mb [2], my [2], mz [2];
  logic [3:0] mxs [2], mys [2], mzs [2];
  typedef struct {
    int s;
    logic [0:5] f;
    logic [7:0] i1, i2, i3, x, y, res;
    int exp_done;
    bit exp_wr;
    logic [7:0] exp_a, exp_b, exp_z;
  } vec_t;
  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      ma[s] = 0; mb[s] = 0; my[s] = 0; mz[s] = 0;
      mxs[s] = 0; mys[s] = 0; mzs[s] = 0;
    end
  endtask
  task automatic chk_all(input int s, input logic er, input logic ed, input logic ex, input logic ey, input logic ez);
    cmp("ready", o_ready, er);
    cmp("busy", o_busy, !er);
    cmp("done", o_done, ed);
    cmp("x_enb", o_xen, ex);
    cmp("y_enb", o_yen, ey);
    cmp("z_enb", o_zen, ez);
    cmp("a", o_a, ma[s]);
    cmp("b", o_b, mb[s]);
    cmp("z", o_z, mz[s]);
    cmp("x_sel", o_xs, mxs[s]);
    cmp("y_sel", o_ys, mys[s]);
    cmp("z_sel", o_zs, mzs[s]);
  endtask
  task automatic run_op(input int s, input logic [0:5] f, input logic [7:0] vi1, vi2, vi3, vx, vy, vr,
                        output int dobs, output bit wobs);
    int wt = s ? 3 : 1;
    bit rd = f[4] | f[5];
    int e0 = rd ? 3 : 1;
    bit wr = f[3] && (f[0:1] != 2'd0);
    int wc = e0 + wt;
    int dc = e0 + wt + int'(wr);
    dobs = 0;
    wobs = 0;
    sel = s[0];
    @(negedge clk);
    chk_all(s, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    flags = f; i1 = vi1; i2 = vi2; i3 = vi3; x = vx; y = vy; result = vr; start = 1'b1;
    for (int k = 1; k <= dc; k++) begin
      @(negedge clk);
      if (k == 1 && rd) begin
        mxs[s] = vi2[3:0];
        mys[s] = vi3[3:0];
      end
      if (k == e0) begin
        if (f[4]) ma[s] = vx;
        if (f[5]) my[s] = vy;
        mb[s] = f[2] ? my[s] : vi3;
      end
      if (wr && k == wc) begin
        mzs[s] = vi1[3:0];
        mz[s] = (f[0:1] == 2'd1) ? vi2 : (f[0:1] == 2'd2) ? ma[s] : vr;
      end
      chk_all(s, 1'b0, k == dc, k == 1 && f[4], k == 1 && f[5], wr && k == wc);
      if (o_done === 1'b1) dobs = k;
      if (o_zen === 1'b1) wobs = 1;
      start = 1'($urandom);
      flags = 6'($urandom);
      i1 = 8'($urandom);
      i2 = 8'($urandom);
      i3 = 8'($urandom);
    end
    start = 1'b0;
  endtask
  vec_t tbl [5];
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int dobs;
    bit wobs;
    tbl[0] = '{0, 6'b111111, 8'd3, 8'd1, 8'd2, 8'h10, 8'h05, 8'h15, 5, 1, 8'h10, 8'h05, 8'h15};
    tbl[1] = '{0, 6'b010100, 8'd4, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 3, 1, 8'h10, 8'h00, 8'hA5};
    tbl[2] = '{0, 6'b000110, 8'd6, 8'd9, 8'h44, 8'h33, 8'h00, 8'h00, 4, 0, 8'h33, 8'h44, 8'hA5};
    tbl[3] = '{1, 6'b110111, 8'd5, 8'd2, 8'h07, 8'h20, 8'h99, 8'h27, 7, 1, 8'h20, 8'h07, 8'h27};
    tbl[4] = '{0, 6'b101110, 8'd7, 8'd3, 8'h00, 8'h5A, 8'h00, 8'h00, 5, 1, 8'h5A, 8'h05, 8'h5A};
    model_reset();
    sel = 1'b0; reset = 1'b1; start = 1'b1; flags = 6'b111111;
    i1 = 8'd1; i2 = 8'd2; i3 = 8'd3; x = 8'h11; y = 8'h22; result = 8'h33;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sel = 1'b1;
    #1;
    chk_all(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; start = 1'b0;
    foreach (tbl[n]) begin
      run_op(tbl[n].s, tbl[n].f, tbl[n].i1, tbl[n].i2, tbl[n].i3, tbl[n].x, tbl[n].y, tbl[n].res, dobs, wobs);
      cmp($sformatf("vec%0d_done_cycle", n), dobs, tbl[n].exp_done);
      cmp($sformatf("vec%0d_wrote", n), 32'(wobs), 32'(tbl[n].exp_wr));
      cmp($sformatf("vec%0d_a", n), o_a, tbl[n].exp_a);
      cmp($sformatf("vec%0d_b", n), o_b, tbl[n].exp_b);
      cmp($sformatf("vec%0d_z", n), o_z, tbl[n].exp_z);
    end
    sel = 1'b0;
    @(negedge clk);
    flags = 6'b111111; i1 = 8'd9; i2 = 8'd1; i3 = 8'd2; x = 8'h77; y = 8'h66; result = 8'hEE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmp("midreset_read", o_xen, 1'b1);
    @(negedge clk);
    @(negedge clk);
    cmp("midreset_exec_busy", o_busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk_all(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_all(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int n = 0; n < 200; n++) begin
      run_op(int'($urandom_range(0, 1)), 6'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom), dobs, wobs);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
